// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// sequencing FSM states and the PC register index.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forward-select comparator chain for one ID source operand.
// The youngest producer wins; R15 is never forwarded.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic             uses_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_en_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_en_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_en_i,
    output logic [1:0]       sel_o,
    output logic             ex_hit_o
);

    logic live;

    assign live     = uses_i && (rs_i != REG_W'(REG_PC));
    assign ex_hit_o = live && ex_en_i && (ex_rd_i == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (live) begin
            if (ex_en_i && (ex_rd_i == rs_i)) begin
                sel_o = FWD_EX;
            end else if (mem_en_i && (mem_rd_i == rs_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_en_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing: operand forwarding, load-use stall and
// taken-branch flush FSM, plus saturating bring-up event counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_uses_Rn,
    input  logic             ID_uses_Rm,
    input  logic             ID_uses_Rd,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             EX_RF_enable,
    input  logic             EX_load_instr,
    input  logic [REG_W-1:0] MEM_Rd,
    input  logic             MEM_RF_enable,
    input  logic [REG_W-1:0] WB_Rd,
    input  logic             WB_RF_enable,
    input  logic             EX_branch_taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_flush,
    output logic             CU_S,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_D,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output state_t           state_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic [1:0]       sel_a, sel_b, sel_d;
    logic             hit_a, hit_b, hit_d;
    logic             luse, luse_eff;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs_i(ID_Rn), .uses_i(ID_uses_Rn),
        .ex_rd_i(EX_Rd), .ex_en_i(EX_RF_enable),
        .mem_rd_i(MEM_Rd), .mem_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_en_i(WB_RF_enable),
        .sel_o(sel_a), .ex_hit_o(hit_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs_i(ID_Rm), .uses_i(ID_uses_Rm),
        .ex_rd_i(EX_Rd), .ex_en_i(EX_RF_enable),
        .mem_rd_i(MEM_Rd), .mem_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_en_i(WB_RF_enable),
        .sel_o(sel_b), .ex_hit_o(hit_b)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_d (
        .rs_i(ID_Rd), .uses_i(ID_uses_Rd),
        .ex_rd_i(EX_Rd), .ex_en_i(EX_RF_enable),
        .mem_rd_i(MEM_Rd), .mem_en_i(MEM_RF_enable),
        .wb_rd_i(WB_Rd), .wb_en_i(WB_RF_enable),
        .sel_o(sel_d), .ex_hit_o(hit_d)
    );

    assign luse = EX_load_instr && (hit_a || hit_b || hit_d);

    assign fwd_A = R ? FWD_RF : sel_a;
    assign fwd_B = R ? FWD_RF : sel_b;
    assign fwd_D = R ? FWD_RF : sel_d;

    always_comb begin
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_flush = 1'b0;
        CU_S        = 1'b0;
        state_d     = ST_RUN;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        // EX holds a bubble in LDSTALL; the load has moved on to MEM.
        case (state_q)
            ST_LDSTALL: luse_eff = 1'b0;
            default:    luse_eff = luse;
        endcase

        if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            CU_S        = 1'b1;
            state_d     = ST_FLUSH;
            flush_inc   = 1'b1;
        end else if (luse_eff) begin
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            CU_S      = 1'b1;
            state_d   = ST_LDSTALL;
            stall_inc = 1'b1;
        end

        if (R) begin
            PC_LE       = 1'b1;
            IF_ID_LE    = 1'b1;
            IF_ID_flush = 1'b0;
            CU_S        = 1'b0;
            state_d     = ST_RUN;
            stall_inc   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipeline_hazard_ctrl; a 4-bit-counter
// twin shares the stimulus so counter saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    logic       clk;
    logic       R;
    logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
    logic       ID_uses_Rn, ID_uses_Rm, ID_uses_Rd;
    logic       EX_RF_enable, EX_load_instr, MEM_RF_enable, WB_RF_enable;
    logic       EX_branch_taken;

    logic        PC_LE, IF_ID_LE, IF_ID_flush, CU_S;
    logic [1:0]  fwd_A, fwd_B, fwd_D;
    logic [15:0] stall_count, flush_count;
    state_t      state_o;

    logic        s_PC_LE, s_IF_ID_LE, s_IF_ID_flush, s_CU_S;
    logic [1:0]  s_fwd_A, s_fwd_B, s_fwd_D;
    logic [3:0]  s_stall_count, s_flush_count;
    state_t      s_state_o;

    logic [43:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .R(R),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm), .ID_uses_Rd(ID_uses_Rd),
        .EX_Rd(EX_Rd), .EX_RF_enable(EX_RF_enable), .EX_load_instr(EX_load_instr),
        .MEM_Rd(MEM_Rd), .MEM_RF_enable(MEM_RF_enable),
        .WB_Rd(WB_Rd), .WB_RF_enable(WB_RF_enable),
        .EX_branch_taken(EX_branch_taken),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_flush(IF_ID_flush), .CU_S(CU_S),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .fwd_D(fwd_D),
        .stall_count(stall_count), .flush_count(flush_count), .state_o(state_o)
    );

    pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(4)) dut_sat (
        .clk(clk), .R(R),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm), .ID_uses_Rd(ID_uses_Rd),
        .EX_Rd(EX_Rd), .EX_RF_enable(EX_RF_enable), .EX_load_instr(EX_load_instr),
        .MEM_Rd(MEM_Rd), .MEM_RF_enable(MEM_RF_enable),
        .WB_Rd(WB_Rd), .WB_RF_enable(WB_RF_enable),
        .EX_branch_taken(EX_branch_taken),
        .PC_LE(s_PC_LE), .IF_ID_LE(s_IF_ID_LE), .IF_ID_flush(s_IF_ID_flush), .CU_S(s_CU_S),
        .fwd_A(s_fwd_A), .fwd_B(s_fwd_B), .fwd_D(s_fwd_D),
        .stall_count(s_stall_count), .flush_count(s_flush_count), .state_o(s_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sat4(input logic [15:0] x);
        return (x > 16'd15) ? 4'hF : x[3:0];
    endfunction

    // monitor: pops one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [43:0] e, a;
            logic [19:0] es, as_;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            a   = {PC_LE, IF_ID_LE, IF_ID_flush, CU_S, fwd_A, fwd_B, fwd_D,
                   state_o, stall_count, flush_count};
            es  = {e[43:32], sat4(e[31:16]), sat4(e[15:0])};
            as_ = {s_PC_LE, s_IF_ID_LE, s_IF_ID_flush, s_CU_S, s_fwd_A, s_fwd_B,
                   s_fwd_D, s_state_o, s_stall_count, s_flush_count};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL %s main act=%h exp=%h (pc,if,fl,cu,fA,fB,fD,st|stall|flush)",
                         nm, a, e);
            end
            checks = checks + 1;
            if (as_ !== es) begin
                errors = errors + 1;
                $display("FAIL %s sat act=%h exp=%h", nm, as_, es);
            end
        end
    end

    // driver tasks
    task automatic clr();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rd = 4'd0;
        ID_uses_Rn = 1'b0; ID_uses_Rm = 1'b0; ID_uses_Rd = 1'b0;
        EX_Rd = 4'd0; EX_RF_enable = 1'b0; EX_load_instr = 1'b0;
        MEM_Rd = 4'd0; MEM_RF_enable = 1'b0;
        WB_Rd = 4'd0; WB_RF_enable = 1'b0;
        EX_branch_taken = 1'b0;
    endtask

    task automatic luse_rm2();
        EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd2;
        ID_Rm = 4'd2; ID_uses_Rm = 1'b1;
    endtask

    task automatic luse_rn9();
        EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_Rd = 4'd9;
        ID_Rn = 4'd9; ID_uses_Rn = 1'b1;
    endtask

    // push expectation for the current cycle, then advance to #1 after the next edge
    task automatic chk(input string nm, input logic pc, input logic ifl,
                       input logic fl, input logic cu, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [1:0] fd,
                       input state_t st, input int sc, input int fc);
        exp_q.push_back({pc, ifl, fl, cu, fa, fb, fd, st, 16'(sc), 16'(fc)});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        R = 1'b1;
        clr();
        @(posedge clk);
        #1;

        // reset forces normal outputs and zero forward selects
        ID_Rn = 4'd1; ID_uses_Rn = 1'b1; EX_Rd = 4'd1; EX_RF_enable = 1'b1;
        EX_load_instr = 1'b1; EX_branch_taken = 1'b1;
        chk("rst_force", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 0, 0);

        // forwarding priority
        R = 1'b0; clr();
        ID_Rn = 4'd1; ID_uses_Rn = 1'b1; EX_Rd = 4'd1; EX_RF_enable = 1'b1;
        chk("t1_ex", 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd1; ID_uses_Rn = 1'b1; EX_Rd = 4'd1;
        MEM_Rd = 4'd1; MEM_RF_enable = 1'b1;
        chk("t1_mem", 1, 1, 0, 0, 2'b10, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd1; ID_uses_Rn = 1'b1; WB_Rd = 4'd1; WB_RF_enable = 1'b1;
        chk("t1_wb", 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd1; ID_uses_Rn = 1'b1; EX_Rd = 4'd1; EX_RF_enable = 1'b1;
        MEM_Rd = 4'd1; MEM_RF_enable = 1'b1;
        chk("t1_exmem", 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd1; ID_uses_Rn = 1'b1; MEM_Rd = 4'd1; MEM_RF_enable = 1'b1;
        WB_Rd = 4'd1; WB_RF_enable = 1'b1;
        chk("t1_memwb", 1, 1, 0, 0, 2'b10, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd1; EX_Rd = 4'd1; EX_RF_enable = 1'b1;
        chk("t1_unused", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rn = 4'd7; ID_uses_Rn = 1'b1; ID_Rm = 4'd5; ID_uses_Rm = 1'b1;
        ID_Rd = 4'd3; ID_uses_Rd = 1'b1; WB_Rd = 4'd5; WB_RF_enable = 1'b1;
        MEM_Rd = 4'd3; MEM_RF_enable = 1'b1;
        chk("t1_bd", 1, 1, 0, 0, 2'b00, 2'b11, 2'b10, ST_RUN, 0, 0);
        clr(); ID_Rd = 4'd6; ID_uses_Rd = 1'b1; EX_Rd = 4'd6; EX_RF_enable = 1'b1;
        chk("t1_d_ex", 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, ST_RUN, 0, 0);

        // load-use stall on Rm
        clr(); luse_rm2();
        chk("t2_luse", 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, ST_RUN, 0, 0);
        clr(); ID_Rm = 4'd2; ID_uses_Rm = 1'b1; MEM_Rd = 4'd2; MEM_RF_enable = 1'b1;
        chk("t2_ldstall", 1, 1, 0, 0, 2'b00, 2'b10, 2'b00, ST_LDSTALL, 1, 0);
        clr();
        chk("t2_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 1, 0);

        // load-use on store data; detection suppressed while in LDSTALL
        clr(); ID_Rd = 4'd4; ID_uses_Rd = 1'b1; EX_Rd = 4'd4; EX_RF_enable = 1'b1;
        EX_load_instr = 1'b1;
        chk("t2b_luse", 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, ST_RUN, 1, 0);
        chk("t2b_supp", 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, ST_LDSTALL, 2, 0);
        clr();
        chk("t2b_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 2, 0);

        // branch beats load-use
        clr(); luse_rm2(); EX_branch_taken = 1'b1;
        chk("t3_br_luse", 1, 1, 1, 1, 2'b00, 2'b01, 2'b00, ST_RUN, 2, 0);
        clr();
        chk("t3_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_FLUSH, 2, 1);
        chk("t3_run", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 2, 1);
        // FLUSH -> LDSTALL, then branch inside LDSTALL
        EX_branch_taken = 1'b1;
        chk("t3_br2", 1, 1, 1, 1, 2'b00, 2'b00, 2'b00, ST_RUN, 2, 1);
        clr(); luse_rn9();
        chk("t3_fl_luse", 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ST_FLUSH, 2, 2);
        clr(); EX_branch_taken = 1'b1;
        chk("t3_ld_br", 1, 1, 1, 1, 2'b00, 2'b00, 2'b00, ST_LDSTALL, 3, 2);
        clr();
        chk("t3_fl2", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_FLUSH, 3, 3);
        chk("t3_run2", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 3, 3);

        // R15 never forwarded nor stalled on
        clr(); ID_Rn = 4'hF; ID_uses_Rn = 1'b1; EX_Rd = 4'hF; EX_RF_enable = 1'b1;
        EX_load_instr = 1'b1;
        chk("t4_pc", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 3, 3);
        clr();
        chk("t4_next", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 3, 3);

        // reset during LDSTALL
        clr(); luse_rm2();
        chk("t5_luse", 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, ST_RUN, 3, 3);
        R = 1'b1; EX_branch_taken = 1'b1;
        chk("t5_rst", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_LDSTALL, 4, 3);
        R = 1'b0; clr();
        chk("t5_after", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 0, 0);

        // back-to-back load-use events; the 4-bit twin saturates at 15
        for (k = 0; k < 18; k++) begin
            clr(); luse_rm2();
            chk("t6_luse", 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, ST_RUN, k, 0);
            clr();
            chk("t6_stall", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_LDSTALL, k + 1, 0);
        end
        chk("t6_end", 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ST_RUN, 18, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors = errors + 1;
        $display("FAIL timeout act=running required=done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage ARM pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives the PC load enable, the IF/ID load enable, the IF/ID flush and the control-unit NOP mux select S.
- Generates operand-forwarding selects for the A, B and store-data (D) operands.
- Contains a small FSM that handles load-use stalls and taken-branch flushes, plus saturating event counters for bring-up.

Parameters:
- REG_W, 4, register-specifier width (16 architectural registers).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock. Everything updates on the rising edge.
- R  in  1  synchronous, active-high reset.
- ID_Rn  in  REG_W  first source register of the instruction in ID.
- ID_Rm  in  REG_W  second source register of the instruction in ID.
- ID_Rd  in  REG_W  store-data source register of the instruction in ID.
- ID_uses_Rn  in  1  the ID instruction reads Rn.
- ID_uses_Rm  in  1  the ID instruction reads Rm.
- ID_uses_Rd  in  1  the ID instruction reads Rd (store).
- EX_Rd  in  REG_W  destination register in EX.
- EX_RF_enable  in  1  the EX instruction writes the register file.
- EX_load_instr  in  1  the EX instruction is a load.
- MEM_Rd  in  REG_W  destination register in MEM.
- MEM_RF_enable  in  1  MEM writeback pending.
- WB_Rd  in  REG_W  destination register in WB.
- WB_RF_enable  in  1  WB writeback pending.
- EX_branch_taken  in  1  branch/BL in EX with condition passed.
- PC_LE  out  1  PC load enable.
- IF_ID_LE  out  1  IF/ID load enable.
- IF_ID_flush  out  1  drives the IF/ID R input.
- CU_S  out  1  NOP-insert select to the CU mux.
- fwd_A  out  2  forward select for Rn.
- fwd_B  out  2  forward select for Rm.
- fwd_D  out  2  forward select for Rd (store data).
- stall_count  out  CNT_W  load-use stall cycles.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:

Forwarding:
- Purely combinational.
- Select encoding: 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- For each operand X in {Rn, Rm, Rd}: if uses_X is 0, or ID_X equals 4'hF (R15/PC is never forwarded), the select is 00.
- Otherwise the first match in this order wins:
  - EX_RF_enable and EX_Rd equals X → 01
  - MEM_RF_enable and MEM_Rd equals X → 10
  - WB_RF_enable and WB_Rd equals X → 11
  - no match → 00
- An EX match on a load still selects 01; the stall logic makes that value irrelevant.

Load-use detect (comb):
- luse is true when EX_load_instr, EX_RF_enable, and EX_Rd matches any used, non-R15 source in ID.

FSM states:
- RUN, LDSTALL, FLUSH. State is registered; outputs are Mealy-combinational.

RUN:
- If EX_branch_taken: IF_ID_flush=1, CU_S=1, PC_LE=1, IF_ID_LE=1. Next state FLUSH; flush_count increments.
- Else if luse: PC_LE=0, IF_ID_LE=0, CU_S=1, IF_ID_flush=0. Next state LDSTALL; stall_count increments.
- Else: PC_LE=1, IF_ID_LE=1, CU_S=0, IF_ID_flush=0. Stay in RUN.

LDSTALL:
- luse detection is suppressed, because EX now holds a bubble and the load sits in MEM (forward select 10).
- Outputs are the normal RUN values.
- Next state: RUN.
- If EX_branch_taken is nonetheless asserted (illegal, since EX holds a bubble), apply the RUN branch action.

FLUSH:
- Outputs are normal.
- luse is evaluated as in RUN. The bubble in EX cannot match, so luse is effectively 0.
- Next state RUN, or LDSTALL/FLUSH by the RUN rules.

Priority:
- A taken branch beats load-use in the same cycle. The stalled ID instruction lies on the wrong path, so no stall is counted.

Counters:
- Increment by 1 on the qualifying edge.
- Saturate at all-ones with no wrap.

Reset (R=1, sampled at the edge):
- Next state RUN; stall_count and flush_count become 0.
- While R=1, outputs are forced: PC_LE=1, IF_ID_LE=1, CU_S=0, IF_ID_flush=0, all fwd selects 00.
- Reset mid-stall or mid-flush abandons the sequence with no further bubble.

Latency:
- A load-use stall costs exactly 1 bubble.
- A taken branch costs a 1-cycle flush of IF/ID plus 1 ID/EX bubble.

Decomposition:
- Shared package pipe_pkg holds:
  - the FWD_RF, FWD_EX, FWD_MEM, FWD_WB localparams (2'b00..2'b11);
  - the FSM state encodings ST_RUN, ST_LDSTALL, ST_FLUSH;
  - the PC register index REG_PC = 4'hF.
- One sub-module, fwd_sel, holds the comparator chain for a single operand and is instantiated three times (A, B, D).
- The FSM and counters stay in the top module.

Test Plan:
1. ADD R1,… in EX with RF_enable, ID uses Rn=R1 → fwd_A=01. Then MEM_Rd=R1 only → fwd_A=10. Then WB_Rd=R1 only → fwd_A=11. With EX_Rd=MEM_Rd=R1 both enabled → fwd_A=01.
2. LDR R2 in EX, ID Rm=R2 → that cycle PC_LE=0, IF_ID_LE=0, CU_S=1. Next cycle LDSTALL with all outputs normal and fwd_B=10. stall_count=1.
3. EX_branch_taken=1 while luse is also true → IF_ID_flush=1, CU_S=1, PC_LE=1. flush_count=1, stall_count unchanged. Next cycle outputs are normal.
4. ID Rn=R15, EX_Rd=R15 with RF_enable and load → fwd_A=00, no stall.
5. Assert R during LDSTALL → next cycle state RUN and counters 0. With R=1: PC_LE=1, CU_S=0, fwd selects 00.
6. Force 65535 load-use events → stall_count holds at 16'hFFFF.
